psg_wt_bus_sched: RTL and testbench

Round-robin bus scheduler for the PSG wave-table channels. It collects up to NCH channel fetch requests, each with its own address. It runs one read cycle at a time on the system bus (cyc/stb/ack master handshake) and returns the fetched sample with a one-clock completion pulse to the owning channel. It sits between the wave-table channels and the system-bus arbitration tree, and presents a single bus master upward.

---
 rtl/psg_sched_pkg.sv | 17 +
 rtl/psg_rr_pick.sv | 27 ++
 rtl/psg_wt_bus_sched.sv | 166 ++++++++++++++++
 tb/tb_psg_wt_bus_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_sched_pkg.sv
// Shared constants for the PSG wave-table bus scheduler.
// Optional timeout support is enabled with PSG_SCHED_TIMEOUT_EN.
package psg_sched_pkg;

    localparam int unsigned NCH_DEF = 8;
    localparam int unsigned AW_DEF  = 24;
    localparam int unsigned DW_DEF  = 16;
    localparam int unsigned TMO_DEF = 255;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned ST_W  = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_BUS  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/psg_rr_pick.sv
// Rotating-priority encoder: first set request after index last_i, wrapping modulo NCH.
module psg_rr_pick #(
    parameter int unsigned NCH = 8
) (
    input  logic [NCH-1:0] req_i,
    input  logic [2:0]     last_i,
    output logic [2:0]     win_o,
    output logic           vld_o
);

    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        win_o = 3'd0;
        for (int k = 1; k <= int'(NCH); k++) begin
            idx = (int'(last_i) + k) % int'(NCH);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win_o = 3'(idx);
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/psg_wt_bus_sched.sv
// Round-robin bus scheduler: one read cycle at a time for up to NCH wave-table channels.
// Optional bus-cycle timeout is enabled with PSG_SCHED_TIMEOUT_EN.
module psg_wt_bus_sched
    import psg_sched_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned DW  = DW_DEF
`ifdef PSG_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TMO = TMO_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*AW-1:0] ch_adr,
    output logic [NCH-1:0]    ch_ack,
    output logic [NCH-1:0]    ch_err,
    output logic [DW-1:0]     ch_dat,
    output logic [2:0]        seln,
    output logic              cyc_o,
    output logic              stb_o,
    output logic [AW-1:0]     adr_o,
    input  logic              ack_i,
    input  logic [DW-1:0]     dat_i
);

    logic [ST_W-1:0] state_q, state_d;
    logic            cyc_q, cyc_d;
    logic [2:0]      seln_q, seln_d;
    logic [2:0]      last_q, last_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [NCH-1:0]  ack_q, ack_d;

    logic [2:0]      pick_win;
    logic            pick_vld;
    logic [AW-1:0]   adr_sel;

`ifdef PSG_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0]  err_q, err_d;
`endif

    psg_rr_pick #(
        .NCH (NCH)
    ) u_pick (
        .req_i  (ch_req),
        .last_i (last_q),
        .win_o  (pick_win),
        .vld_o  (pick_vld)
    );

    // Address of the channel that would win this cycle.
    always_comb begin
        adr_sel = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (pick_win == 3'(k)) begin
                adr_sel = ch_adr[k*AW +: AW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        seln_d  = seln_q;
        last_d  = last_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        ack_d   = '0;
`ifdef PSG_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ce && pick_vld) begin
                    seln_d  = pick_win;
                    adr_d   = adr_sel;
                    cyc_d   = 1'b1;
                    state_d = ST_BUS;
`ifdef PSG_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUS: begin
                // A bus ack on the timeout clock still counts as a normal completion.
                if (ack_i) begin
                    dat_d   = dat_i;
                    ack_d   = NCH'(1) << seln_q;
                    cyc_d   = 1'b0;
                    last_d  = seln_q;
                    state_d = ST_DONE;
                end
`ifdef PSG_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TMO - 1)) begin
                    dat_d   = '0;
                    ack_d   = NCH'(1) << seln_q;
                    err_d   = NCH'(1) << seln_q;
                    cyc_d   = 1'b0;
                    last_d  = seln_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            seln_q  <= 3'd0;
            last_q  <= 3'(NCH - 1);
            adr_q   <= '0;
            dat_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            seln_q  <= seln_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
        end
    end

`ifdef PSG_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign ch_err = err_q;
`else
    assign ch_err = '0;
`endif

    assign ch_ack = ack_q;
    assign ch_dat = dat_q;
    assign seln   = seln_q;
    assign cyc_o  = cyc_q;
    assign stb_o  = cyc_q;
    assign adr_o  = adr_q;

endmodule

// File: tb/tb_psg_wt_bus_sched.sv
// Scoreboard bench for psg_wt_bus_sched; covers the timeout path when PSG_SCHED_TIMEOUT_EN is defined.
module tb_psg_wt_bus_sched;

    localparam int unsigned NCH = 8;
    localparam int unsigned AW  = 24;
    localparam int unsigned DW  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ce;
    logic [NCH-1:0]    ch_req;
    logic [NCH*AW-1:0] ch_adr;
    logic [NCH-1:0]    ch_ack;
    logic [NCH-1:0]    ch_err;
    logic [DW-1:0]     ch_dat;
    logic [2:0]        seln;
    logic              cyc_o;
    logic              stb_o;
    logic [AW-1:0]     adr_o;
    logic              ack_i;
    logic [DW-1:0]     dat_i;

    typedef struct {
        logic [2:0]    sel;
        logic [AW-1:0] adr;
    } grant_t;

    typedef struct {
        logic [NCH-1:0] ack;
        logic [NCH-1:0] err;
        logic [DW-1:0]  dat;
        logic [2:0]     sel;
    } comp_t;

    grant_t gq[$];
    comp_t  cq[$];

    int n_tests = 0;
    int n_fail  = 0;

    psg_wt_bus_sched #(
        .NCH (NCH),
        .AW  (AW),
        .DW  (DW)
`ifdef PSG_SCHED_TIMEOUT_EN
        ,
        .TMO (4)
`endif
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .ch_req (ch_req),
        .ch_adr (ch_adr),
        .ch_ack (ch_ack),
        .ch_err (ch_err),
        .ch_dat (ch_dat),
        .seln   (seln),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .adr_o  (adr_o),
        .ack_i  (ack_i),
        .dat_i  (dat_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] adr_of(input int i);
        logic [AW-1:0] base;
        base = 24'h001000;
        return base + AW'(i) * 24'h000100;
    endfunction

    task automatic exp_grant(input int i);
        grant_t g;
        g.sel = 3'(i);
        g.adr = adr_of(i);
        gq.push_back(g);
    endtask

    task automatic exp_comp(input int i, input logic [DW-1:0] d, input logic e);
        comp_t c;
        c.ack = NCH'(1) << i;
        c.err = e ? (NCH'(1) << i) : '0;
        c.dat = d;
        c.sel = 3'(i);
        cq.push_back(c);
    endtask

    // Monitor: checks every new bus cycle and every completion pulse against the queues.
    logic cyc_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc_o && !cyc_prev) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 64'(seln), 64'hFF);
                end else begin
                    grant_t g;
                    g = gq.pop_front();
                    chk("grant_seln", 64'(seln), 64'(g.sel));
                    chk("grant_adr", 64'(adr_o), 64'(g.adr));
                    chk("grant_stb", 64'(stb_o), 64'(1));
                end
            end
            if (ch_ack != '0) begin
                if (cq.size() == 0) begin
                    chk("ack_unexpected", 64'(ch_ack), 64'(0));
                end else begin
                    comp_t c;
                    c = cq.pop_front();
                    chk("comp_ack", 64'(ch_ack), 64'(c.ack));
                    chk("comp_err", 64'(ch_err), 64'(c.err));
                    chk("comp_dat", 64'(ch_dat), 64'(c.dat));
                    chk("comp_seln", 64'(seln), 64'(c.sel));
                end
            end
        end
        cyc_prev = cyc_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc();
        int n;
        n = 0;
        while (!cyc_o && n < 50) begin
            tick();
            n++;
        end
        chk("cyc_seen", 64'(cyc_o), 64'(1));
    endtask

    task automatic bus_ack(input int dly, input logic [DW-1:0] d);
        wait_cyc();
        repeat (dly) tick();
        ack_i = 1'b1;
        dat_i = d;
        tick();
        ack_i = 1'b0;
        dat_i = '0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ce     = 1'b0;
        ch_req = '0;
        ack_i  = 1'b0;
        dat_i  = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(NCH); i++) ch_adr[i*AW +: AW] = adr_of(i);
        rst_n  = 1'b0;
        ce     = 1'b0;
        ch_req = '0;
        ack_i  = 1'b0;
        dat_i  = '0;
        repeat (2) tick();
        chk("rst_cyc", 64'(cyc_o), 64'(0));
        chk("rst_stb", 64'(stb_o), 64'(0));
        chk("rst_adr", 64'(adr_o), 64'(0));
        chk("rst_dat", 64'(ch_dat), 64'(0));
        chk("rst_seln", 64'(seln), 64'(0));
        chk("rst_ack", 64'(ch_ack), 64'(0));
        chk("rst_err", 64'(ch_err), 64'(0));
        rst_n = 1'b1;
        tick();

        // 1: single fetch from channel 0
        ch_req = 8'h01;
        ce     = 1'b1;
        exp_grant(0);
        exp_comp(0, 16'hBEEF, 1'b0);
        tick();
        chk("t1_cyc_latency", 64'(cyc_o), 64'(1));
        chk("t1_adr", 64'(adr_o), 64'h001000);
        bus_ack(0, 16'hBEEF);
        chk("t1_ack", 64'(ch_ack), 64'h01);
        chk("t1_dat", 64'(ch_dat), 64'hBEEF);
        chk("t1_cyc_drop", 64'(cyc_o), 64'(0));
        ch_req = '0;
        tick();
        chk("t1_ack_pulse", 64'(ch_ack), 64'(0));

        // 2: all channels held, grants rotate 0..7,0
        do_reset();
        ce     = 1'b1;
        ch_req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_grant(k % 8);
            exp_comp(k % 8, 16'hA000 + 16'(k), 1'b0);
            bus_ack(2, 16'hA000 + 16'(k));
        end

        // 3: last=2, then 8'h84 -> 7 before 2
        ch_req = 8'h04;
        exp_grant(2);
        exp_comp(2, 16'h3330, 1'b0);
        bus_ack(1, 16'h3330);
        ch_req = 8'h84;
        exp_grant(7);
        exp_comp(7, 16'h3337, 1'b0);
        bus_ack(1, 16'h3337);
        exp_grant(2);
        exp_comp(2, 16'h3332, 1'b0);
        bus_ack(1, 16'h3332);
        ch_req = '0;

        // 4: ce gating in IDLE, ce ignored in BUS
        ce     = 1'b0;
        ch_req = 8'h10;
        repeat (4) tick();
        chk("t4_ce_hold", 64'(cyc_o), 64'(0));
        ce = 1'b1;
        exp_grant(4);
        exp_comp(4, 16'h4444, 1'b0);
        tick();
        ce = 1'b0;
        chk("t4_grant", 64'(cyc_o), 64'(1));
        bus_ack(1, 16'h4444);
        ch_req = '0;
        repeat (2) tick();
        ack_i = 1'b1;
        dat_i = 16'hDEAD;
        tick();
        ack_i = 1'b0;
        dat_i = '0;
        chk("t4_idle_ack_ign", 64'(ch_ack), 64'(0));
        chk("t4_dat_held", 64'(ch_dat), 64'h4444);
        chk("t4_idle_cyc", 64'(cyc_o), 64'(0));

        // 5: reset mid-bus cycle
        ce     = 1'b1;
        ch_req = 8'h0A;
        exp_grant(1);
        wait_cyc();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cyc", 64'(cyc_o), 64'(0));
        chk("t5_rst_stb", 64'(stb_o), 64'(0));
        chk("t5_rst_ack", 64'(ch_ack), 64'(0));
        repeat (2) tick();
        exp_grant(1);
        exp_comp(1, 16'h5555, 1'b0);
        rst_n = 1'b1;
        bus_ack(1, 16'h5555);
        ch_req = 8'h08;
        exp_grant(3);
        exp_comp(3, 16'h6666, 1'b0);
        bus_ack(1, 16'h6666);
        ch_req = '0;
        repeat (2) tick();

        // 6: timeout behaviour
        ch_req = 8'h20;
        exp_grant(5);
`ifdef PSG_SCHED_TIMEOUT_EN
        exp_comp(5, 16'h0000, 1'b1);
        wait_cyc();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_ack_yet", 64'(ch_ack), 64'(0));
        end
        tick();
        chk("t6_tmo_ack", 64'(ch_ack), 64'h20);
        chk("t6_tmo_err", 64'(ch_err), 64'h20);
        chk("t6_tmo_dat", 64'(ch_dat), 64'(0));
        chk("t6_tmo_cyc", 64'(cyc_o), 64'(0));
        exp_grant(5);
        exp_comp(5, 16'h7777, 1'b0);
        wait_cyc();
        repeat (3) tick();
        ack_i = 1'b1;
        dat_i = 16'h7777;
        tick();
        ack_i = 1'b0;
        dat_i = '0;
        chk("t6_ack_wins", 64'(ch_err), 64'(0));
        chk("t6_ack_wins_dat", 64'(ch_dat), 64'h7777);
`else
        wait_cyc();
        repeat (20) tick();
        chk("t6_no_tmo_cyc", 64'(cyc_o), 64'(1));
        chk("t6_no_tmo_ack", 64'(ch_ack), 64'(0));
        exp_comp(5, 16'h7777, 1'b0);
        bus_ack(0, 16'h7777);
        chk("t6_err_tied", 64'(ch_err), 64'(0));
`endif
        ch_req = '0;
        repeat (5) tick();
        chk("grant_queue_empty", 64'(gq.size()), 64'(0));
        chk("comp_queue_empty", 64'(cq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
